bram_fifo_ctrl: RTL and testbench



---
 rtl/bram_fifo_ctrl_pkg.sv | 13 +
 rtl/bram_fifo_obuf.sv | 57 +++++
 rtl/bram_fifo_ctrl.sv | 98 +++++++++
 tb/tb_bram_fifo_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_fifo_ctrl_pkg.sv
// Shared sizing constants for the BRAM-backed FIFO controller and its prefetch buffer.
package bram_fifo_ctrl_pkg;

    localparam int FIFO_ADDR_W = 10;
    localparam int FIFO_DATA_W = 16;
    localparam int FIFO_CNT_W  = FIFO_ADDR_W + 1;

    // Occupancy counters need one extra bit to represent a completely full memory.
    function automatic int cnt_width(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/bram_fifo_obuf.sv
// Two-entry register FIFO that holds words returned from the BRAM read port
// so the head is always available from a flop, independent of read latency.
module bram_fifo_obuf
    import bram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_cnt
);

    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_tail;
    logic [1:0]        r_cnt;
    logic              w_pop;

    assign w_pop   = i_pop & (r_cnt != 2'd0);
    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_head;
    assign o_cnt   = r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= 2'd0;
            r_head <= '0;
        end else begin
            unique case ({i_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_head <= i_push_data;
                    else               r_tail <= i_push_data;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_cnt  <= r_cnt - 2'd1;
                end
                // Simultaneous push and pop keeps the count; the new word lands behind any survivor.
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_head <= i_push_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// Deep elastic FIFO using an external true-dual-port BRAM: port 0 writes on enqueue,
// port 1 prefetches into a 2-entry output buffer so one word per cycle flows each way.
module bram_fifo_ctrl
    import bram_fifo_ctrl_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W,
    parameter int DATA_W = FIFO_DATA_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [DATA_W-1:0] enq_data,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [DATA_W-1:0] deq_data,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] A0,
    output logic [DATA_W-1:0] D0,
    output logic              WE0,
    output logic [DATA_W-1:0] WEM0,
    output logic              CE0,
    output logic [ADDR_W-1:0] A1,
    output logic [DATA_W-1:0] D1,
    output logic              WE1,
    output logic [DATA_W-1:0] WEM1,
    output logic              CE1,
    input  logic [DATA_W-1:0] Q1
);

    localparam int CNT_W = ADDR_W + 1;

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_mem_cnt;
    logic              r_vld_p1;

    logic              w_enq_fire;
    logic              w_deq_fire;
    logic              w_rd_issue;
    logic [1:0]        w_ob_cnt;
    logic [2:0]        w_ob_pending;
    logic [2:0]        w_ob_room;

    assign enq_ready  = (r_mem_cnt < CNT_W'(DEPTH));
    assign w_enq_fire = enq_valid & enq_ready & ~RST;
    assign w_deq_fire = deq_valid & deq_ready;

    // A read is only issued if its data is guaranteed a slot in the output buffer on return.
    assign w_ob_pending = {1'b0, w_ob_cnt} + {2'b00, r_vld_p1};
    assign w_ob_room    = 3'd1 + {2'b00, w_deq_fire};
    assign w_rd_issue   = ~RST & (r_mem_cnt != '0) & (w_ob_pending <= w_ob_room);

    assign A0   = r_wr_ptr;
    assign D0   = enq_data;
    assign WE0  = w_enq_fire;
    assign CE0  = w_enq_fire;
    assign WEM0 = '1;

    assign A1   = r_rd_ptr;
    assign D1   = '0;
    assign WE1  = 1'b0;
    assign WEM1 = '0;
    assign CE1  = w_rd_issue;

    assign count = r_mem_cnt + CNT_W'(r_vld_p1) + CNT_W'(w_ob_cnt);

    // Stage p0 -> p1: read issued to BRAM, data appears on Q1 next cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_mem_cnt <= '0;
            r_vld_p1  <= 1'b0;
        end else begin
            if (w_enq_fire) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_rd_issue) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            r_mem_cnt <= r_mem_cnt + CNT_W'(w_enq_fire) - CNT_W'(w_rd_issue);
            r_vld_p1  <= w_rd_issue;
        end
    end

    // Stage p1 -> p2: returned word captured into the output buffer.
    bram_fifo_obuf #(
        .DATA_W (DATA_W)
    ) u_obuf (
        .i_clk       (CLK),
        .i_rst       (RST),
        .i_push      (r_vld_p1),
        .i_push_data (Q1),
        .i_pop       (deq_ready),
        .o_valid     (deq_valid),
        .o_data      (deq_data),
        .o_cnt       (w_ob_cnt)
    );

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Bench for bram_fifo_ctrl: behavioural BRAM plus a queue model of FIFO contents.
module tb_bram_fifo_ctrl;

    localparam int AW    = 10;
    localparam int DW    = 16;
    localparam int DEPTH = 1024;
    localparam int FULL  = DEPTH + 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          enq_valid = 1'b0;
    logic          enq_ready;
    logic [DW-1:0] enq_data = '0;
    logic          deq_valid;
    logic          deq_ready = 1'b0;
    logic [DW-1:0] deq_data;
    logic [AW:0]   count;
    logic [AW-1:0] A0, A1;
    logic [DW-1:0] D0, D1, WEM0, WEM1;
    logic          WE0, CE0, WE1, CE1;
    logic [DW-1:0] Q1 = '0;

    bram_fifo_ctrl dut (
        .CLK(CLK), .RST(RST),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data),
        .count(count),
        .A0(A0), .D0(D0), .WE0(WE0), .WEM0(WEM0), .CE0(CE0),
        .A1(A1), .D1(D1), .WE1(WE1), .WEM1(WEM1), .CE1(CE1), .Q1(Q1)
    );

    always #5 CLK = ~CLK;

    logic [DW-1:0] bram [0:DEPTH-1];
    always @(posedge CLK) begin
        if (CE0 && WE0) bram[A0] <= D0;
        if (CE1) Q1 <= bram[A1];
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] q[$];
    int            bram_words = 0;

    logic          s_enq_ready, s_deq_valid, s_we0, s_ce0, s_ce1, s_efire, s_dfire;
    logic          s_ce1_bad, s_qempty;
    logic [DW-1:0] s_deq_data, s_head;
    logic [AW:0]   s_count;
    int            s_occ;

    // One clock of stimulus: drive after the falling edge, sample, then advance the model.
    task automatic cycle(input logic rst, input logic ev, input logic [DW-1:0] ed, input logic dr);
        @(negedge CLK);
        RST = rst; enq_valid = ev; enq_data = ed; deq_ready = dr;
        #1;
        s_enq_ready = enq_ready; s_deq_valid = deq_valid; s_deq_data = deq_data;
        s_count = count; s_we0 = WE0; s_ce0 = CE0; s_ce1 = CE1;
        s_occ = q.size(); s_qempty = (q.size() == 0); s_head = s_qempty ? '0 : q[0];
        s_efire = ev && enq_ready && !rst;
        s_dfire = deq_valid && dr && !rst;
        s_ce1_bad = CE1 && (bram_words == 0);
        @(posedge CLK);
        if (rst) begin
            q.delete();
            bram_words = 0;
        end else begin
            if (s_dfire && !s_qempty) void'(q.pop_front());
            if (s_efire) q.push_back(ed);
            bram_words = bram_words + int'(s_we0) - int'(s_ce1);
        end
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1, 16'h1234, 1'b1);
            n_tests++; if (s_we0 !== 1'b0) begin n_fail++; $display("FAIL reset_we0: got %b want 0", s_we0); end
            n_tests++; if (s_ce0 !== 1'b0) begin n_fail++; $display("FAIL reset_ce0: got %b want 0", s_ce0); end
            n_tests++; if (s_ce1 !== 1'b0) begin n_fail++; $display("FAIL reset_ce1: got %b want 0", s_ce1); end
        end
        cycle(1'b0, 1'b0, '0, 1'b0);
        n_tests++; if (s_count !== 11'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", s_count); end
        n_tests++; if (s_deq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_deq_valid: got %b want 0", s_deq_valid); end
        n_tests++; if (s_deq_data !== 16'h0) begin n_fail++; $display("FAIL reset_deq_data: got %h want 0000", s_deq_data); end
        n_tests++; if (s_enq_ready !== 1'b1) begin n_fail++; $display("FAIL reset_enq_ready: got %b want 1", s_enq_ready); end
    endtask

    task automatic test_fill5();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, DW'(i + 1), 1'b0);
            n_tests++;
            if (s_deq_valid !== (i >= 3)) begin
                n_fail++; $display("FAIL fill5_latency cyc%0d: deq_valid got %b want %b", i, s_deq_valid, (i >= 3));
            end
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b0);
        n_tests++; if (s_count !== 11'd5) begin n_fail++; $display("FAIL fill5_count: got %0d want 5", s_count); end
        n_tests++; if (s_deq_valid !== 1'b1) begin n_fail++; $display("FAIL fill5_valid: got %b want 1", s_deq_valid); end
        n_tests++; if (s_deq_data !== 16'h0001) begin n_fail++; $display("FAIL fill5_head: got %h want 0001", s_deq_data); end
        n_tests++; if (s_enq_ready !== 1'b1) begin n_fail++; $display("FAIL fill5_enq_ready: got %b want 1", s_enq_ready); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            cycle(1'b0, 1'b1, DW'(c), 1'b1);
            n_tests++;
            if (s_count !== (AW+1)'(s_occ)) begin
                n_fail++; $display("FAIL stream_count cyc%0d: got %0d want %0d", c, s_count, s_occ);
            end
            if (c >= 3) begin
                n_tests++;
                if (s_deq_valid !== 1'b1 || s_deq_data !== DW'(c - 3)) begin
                    n_fail++; $display("FAIL stream_data cyc%0d: got v=%b d=%h want v=1 d=%h", c, s_deq_valid, s_deq_data, DW'(c - 3));
                end
            end
        end
        for (int c = 0; c < 8; c++) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            if (s_deq_valid) begin
                n_tests++;
                if (s_qempty || s_deq_data !== s_head) begin
                    n_fail++; $display("FAIL stream_drain: got %h want %h (model empty=%b)", s_deq_data, s_head, s_qempty);
                end
            end
        end
        n_tests++; if (s_count !== 11'd0) begin n_fail++; $display("FAIL stream_drained_count: got %0d want 0", s_count); end
    endtask

    task automatic test_full();
        int acc;
        do_reset();
        acc = 0;
        for (int k = 0; k < 1100; k++) begin
            cycle(1'b0, 1'b1, DW'(k), 1'b0);
            if (s_efire) acc++;
            n_tests++;
            if (s_enq_ready !== (s_occ < FULL) || s_we0 !== s_enq_ready) begin
                n_fail++; $display("FAIL full_ready k%0d: ready=%b we0=%b want ready=%b", k, s_enq_ready, s_we0, (s_occ < FULL));
            end
        end
        n_tests++; if (acc !== FULL) begin n_fail++; $display("FAIL full_accepts: got %0d want %0d", acc, FULL); end
        cycle(1'b0, 1'b1, 16'hDEAD, 1'b0);
        n_tests++; if (s_count !== 11'(FULL)) begin n_fail++; $display("FAIL full_count: got %0d want %0d", s_count, FULL); end
        n_tests++; if (s_we0 !== 1'b0 || s_enq_ready !== 1'b0) begin n_fail++; $display("FAIL full_holdoff: we0=%b ready=%b want 0 0", s_we0, s_enq_ready); end
        cycle(1'b0, 1'b0, '0, 1'b1);
        n_tests++; if (s_dfire !== 1'b1 || s_deq_data !== 16'h0000) begin n_fail++; $display("FAIL full_pop: fire=%b d=%h want 1 0000", s_dfire, s_deq_data); end
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b1, DW'(16'hA000 + k), 1'b0);
            if (s_efire) acc++;
            if (k == 0) begin
                n_tests++; if (s_enq_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_return: got %b want 1", s_enq_ready); end
            end
        end
        n_tests++; if (acc !== 1) begin n_fail++; $display("FAIL full_one_more: got %0d accepts want 1", acc); end
        cycle(1'b0, 1'b0, '0, 1'b0);
        n_tests++; if (s_count !== 11'(FULL)) begin n_fail++; $display("FAIL full_refill_count: got %0d want %0d", s_count, FULL); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            cycle(1'b0, 1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
            n_tests++;
            if (s_count !== (AW+1)'(s_occ)) begin n_fail++; $display("FAIL rand_count cyc%0d: got %0d want %0d", c, s_count, s_occ); end
            n_tests++;
            if (s_ce1_bad) begin n_fail++; $display("FAIL rand_ce1_empty cyc%0d: CE1=1 with 0 words stored", c); end
            if (s_deq_valid) begin
                n_tests++;
                if (s_qempty || s_deq_data !== s_head) begin
                    n_fail++; $display("FAIL rand_data cyc%0d: got %h want %h (model empty=%b)", c, s_deq_data, s_head, s_qempty);
                end
            end
        end
        for (int c = 0; c < 2100; c++) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            if (s_deq_valid) begin
                n_tests++;
                if (s_qempty || s_deq_data !== s_head) begin n_fail++; $display("FAIL rand_drain: got %h want %h", s_deq_data, s_head); end
            end
            if (q.size() == 0 && !s_deq_valid) break;
        end
        cycle(1'b0, 1'b0, '0, 1'b0);
        n_tests++; if (q.size() != 0 || s_count !== 11'd0) begin n_fail++; $display("FAIL rand_empty: left %0d count %0d want 0 0", q.size(), s_count); end
    endtask

    task automatic test_reset_midop();
        logic seen;
        do_reset();
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, DW'(i + 100), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b1, 16'h0200, 1'b1);
        n_tests++; if (s_dfire !== 1'b1 || s_ce1 !== 1'b1) begin n_fail++; $display("FAIL mid_setup: pop=%b ce1=%b want 1 1", s_dfire, s_ce1); end
        cycle(1'b1, 1'b1, 16'h5555, 1'b0);
        n_tests++; if (s_count !== 11'd40) begin n_fail++; $display("FAIL mid_count_before: got %0d want 40", s_count); end
        n_tests++; if (s_we0 !== 1'b0 || s_ce1 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ports: we0=%b ce1=%b want 0 0", s_we0, s_ce1); end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b0);
            n_tests++;
            if (s_count !== 11'd0 || s_deq_valid !== 1'b0) begin
                n_fail++; $display("FAIL mid_after_rst cyc%0d: count=%0d valid=%b want 0 0", i, s_count, s_deq_valid);
            end
        end
        cycle(1'b0, 1'b1, 16'hBEEF, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            if (s_deq_valid) begin
                seen = 1'b1;
                n_tests++; if (s_deq_data !== 16'hBEEF) begin n_fail++; $display("FAIL mid_first_value: got %h want beef", s_deq_data); end
            end
        end
        if (!seen) begin n_tests++; n_fail++; $display("FAIL mid_timeout: deq_valid got 0 want 1 within 10 cycles"); end
    endtask

    initial begin
        test_reset();
        test_fill5();
        test_stream();
        test_full();
        test_random();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time got 1000000 want completion earlier");
        $fatal(1, "watchdog expired");
    end

endmodule
